// File: rtl/graphics_pkg.sv
// Shared graphics constants and types for the tile board drawing datapath.
// Screen geometry, colour width, draw-sequencer state encoding, sizing helper.
package graphics_pkg;

  localparam int COLOUR_W   = 3;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int TILE_IDX_W = 2;

  localparam logic [COLOUR_W-1:0] COL_BLACK = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_DONE    = 3'd4
  } draw_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input longint n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// Raster cx/cy counter over a W_CNT x H_CNT rectangle with clear, enable and
// last-pixel flag. Exposes next-state values so callers can register outputs.
module tile_pixel_counter #(
  parameter int W_CNT = 80,
  parameter int H_CNT = 60,
  parameter int CX_W  = 7,
  parameter int CY_W  = 6
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CX_W-1:0] cx_next_o,
  output logic [CY_W-1:0] cy_next_o,
  output logic            last_o
);

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(W_CNT - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(H_CNT - 1);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      if (cx_q == CX_LAST) begin
        cx_d = '0;
        cy_d = (cy_q == CY_LAST) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_next_o = cx_d;
  assign cy_next_o = cy_d;
  assign last_o    = (cx_q == CX_LAST) && (cy_q == CY_LAST);

endmodule

// File: rtl/tile_draw_sequencer.sv
// Tile draw sequencer: req/ack/done handshake, raster FILL, optional HOLD+RESTORE.
// Define TILE_BORDER_EN to paint a black one-pixel border in FILL and RESTORE.
module tile_draw_sequencer
  import graphics_pkg::*;
#(
  parameter int TILE_W       = 80,
  parameter int TILE_H       = 60,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int COL_W        = COLOUR_W,
  parameter int FLASH_CYCLES = 12500000
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic [TILE_IDX_W-1:0] req_tile_i,
  input  logic [COL_W-1:0]      req_colour_i,
  input  logic [COL_W-1:0]      req_restore_i,
  input  logic                  req_flash_i,
  output logic                  ack_o,
  output logic                  busy_o,
  output logic [X_W-1:0]        x_o,
  output logic [Y_W-1:0]        y_o,
  output logic [COL_W-1:0]      colour_o,
  output logic                  plot_o,
  output logic                  done_o
);

  localparam int CX_W  = clog2_min1(TILE_W);
  localparam int CY_W  = clog2_min1(TILE_H);
  localparam int TMR_W = clog2_min1(FLASH_CYCLES + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((FLASH_CYCLES == 0) ? 0 : FLASH_CYCLES - 1);
  localparam logic [X_W-1:0]   X_STEP    = X_W'(TILE_W);
  localparam logic [Y_W-1:0]   Y_STEP    = Y_W'(TILE_H);

  if ((2 * TILE_W > (1 << X_W)) || (2 * TILE_H > (1 << Y_W)) ||
      (2 * TILE_W > SCREEN_W) || (2 * TILE_H > SCREEN_H)) begin : g_bad_geometry
    $error("tile_draw_sequencer: 2x2 board does not fit coordinate width or screen");
  end

  draw_state_e             state_q, state_d;
  logic [TILE_IDX_W-1:0]   tile_q, tile_d;
  logic [COL_W-1:0]        fill_col_q, fill_col_d, rest_col_q, rest_col_d;
  logic                    flash_q, flash_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    cnt_clr, cnt_en, cnt_last;
  logic [CX_W-1:0]         cx_next;
  logic [CY_W-1:0]         cy_next;
  logic                    ack_q, ack_d, busy_q, busy_d, plot_q, plot_d, done_q, done_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [COL_W-1:0]        colour_q, colour_d;

  tile_pixel_counter #(
    .W_CNT(TILE_W), .H_CNT(TILE_H), .CX_W(CX_W), .CY_W(CY_W)
  ) u_counter (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .cx_next_o(cx_next),
    .cy_next_o(cy_next),
    .last_o   (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    fill_col_d = fill_col_q;
    rest_col_d = rest_col_q;
    flash_d    = flash_q;
    timer_d    = '0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    ack_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (req_i) begin
          state_d    = ST_FILL;
          ack_d      = 1'b1;
          tile_d     = req_tile_i;
          fill_col_d = req_colour_i;
          rest_col_d = req_restore_i;
          flash_d    = req_flash_i;
        end
      end
      ST_FILL: begin
        if (cnt_last) state_d = flash_q ? ST_HOLD : ST_DONE;
        else          cnt_en  = 1'b1;
      end
      ST_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = ST_RESTORE;
          cnt_clr = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESTORE: begin
        if (cnt_last) state_d = ST_DONE;
        else          cnt_en  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded from next-state values so every port is a flop.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    plot_d   = (state_d == ST_FILL) || (state_d == ST_RESTORE);
    done_d   = (state_d == ST_DONE);
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (plot_d) begin
      x_d      = (tile_d[0] ? X_STEP : '0) + X_W'(cx_next);
      y_d      = (tile_d[1] ? Y_STEP : '0) + Y_W'(cy_next);
      colour_d = (state_d == ST_FILL) ? fill_col_d : rest_col_d;
`ifdef TILE_BORDER_EN
      if ((cx_next == '0) || (cx_next == CX_W'(TILE_W - 1)) ||
          (cy_next == '0) || (cy_next == CY_W'(TILE_H - 1)))
        colour_d = '0;
`endif
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      tile_q     <= '0;
      fill_col_q <= '0;
      rest_col_q <= '0;
      flash_q    <= 1'b0;
      timer_q    <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      plot_q     <= 1'b0;
      done_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= COL_W'(COL_BLACK);
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      fill_col_q <= fill_col_d;
      rest_col_q <= rest_col_d;
      flash_q    <= flash_d;
      timer_q    <= timer_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      plot_q     <= plot_d;
      done_q     <= done_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
    end
  end

  assign ack_o    = ack_q;
  assign busy_o   = busy_q;
  assign plot_o   = plot_q;
  assign done_o   = done_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = colour_q;

endmodule

// File: tb/tb_tile_draw_sequencer.sv
// Bench for tile_draw_sequencer on a 4x3 tile: table vectors, random requests
// against a per-cycle trace model, and hand sequences for held req and mid-fill reset.
module tb_tile_draw_sequencer;

  localparam int TW = 4, TH = 3, XW = 8, YW = 7, CW = 3, FC = 5;
  localparam int NPIX = TW * TH;
  localparam int HOLD_N = (FC == 0) ? 1 : FC;

  logic          clock, reset, req, req_flash;
  logic [1:0]    req_tile;
  logic [CW-1:0] req_colour, req_restore;
  logic          ack, busy, plot, done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;

  int checks = 0;
  int errors = 0;

  tile_draw_sequencer #(
    .TILE_W(TW), .TILE_H(TH), .X_W(XW), .Y_W(YW), .COL_W(CW), .FLASH_CYCLES(FC)
  ) dut (
    .clock_i(clock), .reset_i(reset), .req_i(req), .req_tile_i(req_tile),
    .req_colour_i(req_colour), .req_restore_i(req_restore), .req_flash_i(req_flash),
    .ack_o(ack), .busy_o(busy), .x_o(x), .y_o(y), .colour_o(colour),
    .plot_o(plot), .done_o(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] ctl;      // {ack, busy, plot, done}
    int         px, py, col;
    bit         care_xy, care_col;
  } exp_t;

  typedef struct {
    logic [1:0]    tile;
    logic [CW-1:0] col, rest;
    logic          flash;
    int            fx, fy, lx, ly, len;
  } vec_t;

  exp_t trace[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pix_col(input int cx, input int cy, input int c);
`ifdef TILE_BORDER_EN
    if (cx == 0 || cx == TW - 1 || cy == 0 || cy == TH - 1) return 0;
`endif
    return c;
  endfunction

  function automatic exp_t mk(input logic [3:0] ctl, input int px, input int py,
                              input int col, input bit cxy, input bit ccol);
    exp_t e;
    e.ctl = ctl; e.px = px; e.py = py; e.col = col; e.care_xy = cxy; e.care_col = ccol;
    return e;
  endfunction

  // Expected per-cycle outputs starting the cycle after the accepting edge.
  task automatic build_trace(input logic [1:0] tile, input int col, input int rest, input bit flash);
    int x0, y0;
    x0 = tile[0] ? TW : 0;
    y0 = tile[1] ? TH : 0;
    trace.delete();
    for (int pass = 0; pass <= (flash ? 1 : 0); pass++) begin
      for (int cy = 0; cy < TH; cy++)
        for (int cx = 0; cx < TW; cx++)
          trace.push_back(mk({trace.size() == 0, 3'b110}, x0 + cx, y0 + cy,
                             pix_col(cx, cy, pass ? rest : col), 1, 1));
      if (pass == 0 && flash)
        for (int h = 0; h < HOLD_N; h++)
          trace.push_back(mk(4'b0100, x0 + TW - 1, y0 + TH - 1, 0, 1, 0));
    end
    trace.push_back(mk(4'b0101, 0, 0, 0, 0, 0));
    trace.push_back(mk(4'b0000, 0, 0, 0, 0, 0));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clock);
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_req(input string tag, input logic [1:0] tile, input logic [CW-1:0] col,
                         input logic [CW-1:0] rest, input logic flash,
                         output int fx, output int fy, output int lx, output int ly,
                         output int len, output int n7);
    fx = -1; fy = -1; lx = -1; ly = -1; len = -1; n7 = 0;
    wait_idle();
    @(negedge clock);
    req_tile = tile; req_colour = col; req_restore = rest; req_flash = flash; req = 1'b1;
    build_trace(tile, int'(col), int'(rest), flash);
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clock);
      if (i == 0) req = 1'b0;
      check($sformatf("%s_ctl[%0d]", tag, i), 64'({ack, busy, plot, done}), 64'(trace[i].ctl));
      if (trace[i].care_xy) begin
        check($sformatf("%s_x[%0d]", tag, i), 64'(x), 64'(trace[i].px));
        check($sformatf("%s_y[%0d]", tag, i), 64'(y), 64'(trace[i].py));
      end
      if (trace[i].care_col)
        check($sformatf("%s_col[%0d]", tag, i), 64'(colour), 64'(trace[i].col));
      if (plot) begin
        if (fx < 0) begin fx = int'(x); fy = int'(y); end
        lx = int'(x); ly = int'(y);
        if (colour == 3'd7) n7++;
      end
      if (done && len < 0) len = i + 1;
    end
    $display("txn %s tile=%0d col=%0d rest=%0d flash=%0d first=(%0d,%0d) last=(%0d,%0d) len=%0d",
             tag, tile, col, rest, flash, fx, fy, lx, ly, len);
  endtask

  vec_t vecs[5];

  initial begin
    int fx, fy, lx, ly, len, n7, nack, bad;
    vecs[0] = '{2'b00, 3'd4, 3'd0, 1'b0, 0, 0, 3, 2, NPIX + 1};
    vecs[1] = '{2'b11, 3'd2, 3'd1, 1'b1, 4, 3, 7, 5, 2 * NPIX + HOLD_N + 1};
    vecs[2] = '{2'b01, 3'd3, 3'd6, 1'b0, 4, 0, 7, 2, NPIX + 1};
    vecs[3] = '{2'b10, 3'd5, 3'd6, 1'b1, 0, 3, 3, 5, 2 * NPIX + HOLD_N + 1};
    vecs[4] = '{2'b00, 3'd7, 3'd0, 1'b0, 0, 0, 3, 2, NPIX + 1};

    reset = 1'b1; req = 1'b0; req_tile = '0; req_colour = '0; req_restore = '0; req_flash = 1'b0;
    #2;
    check("reset_outputs", 64'({ack, busy, plot, done, x, y, colour}), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", 64'({ack, busy, plot, done}), 64'd0);

    for (int v = 0; v < 5; v++) begin
      run_req($sformatf("vec%0d", v), vecs[v].tile, vecs[v].col, vecs[v].rest, vecs[v].flash,
              fx, fy, lx, ly, len, n7);
      check($sformatf("vec%0d_first", v), 64'({fx[15:0], fy[15:0]}), 64'({vecs[v].fx[15:0], vecs[v].fy[15:0]}));
      check($sformatf("vec%0d_last", v), 64'({lx[15:0], ly[15:0]}), 64'({vecs[v].lx[15:0], vecs[v].ly[15:0]}));
      check($sformatf("vec%0d_len", v), 64'(len), 64'(vecs[v].len));
      if (v == 4) begin
`ifdef TILE_BORDER_EN
        check("border_interior_count", 64'(n7), 64'd2);
`else
        check("fill_colour_count", 64'(n7), 64'(NPIX));
`endif
      end
    end

    for (int r = 0; r < 20; r++)
      run_req($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), fx, fy, lx, ly, len, n7);

    // req held high across a whole sequence
    wait_idle();
    @(negedge clock);
    req_tile = 2'b01; req_colour = 3'd3; req_flash = 1'b0; req = 1'b1;
    nack = 0;
    for (int i = 0; i <= NPIX + 2; i++) begin
      @(negedge clock);
      if (i <= NPIX) nack += int'(ack);
      if (i == NPIX) check("held_done_pulse", 64'(done), 64'd1);
      if (i == NPIX + 1) check("held_idle_gap", 64'({busy, ack}), 64'd0);
      if (i == NPIX + 2) check("held_reaccept", 64'({ack, busy}), 64'b11);
    end
    req = 1'b0;
    check("held_single_ack", 64'(nack), 64'd1);
    $display("txn held_req acks_in_first_sequence=%0d", nack);
    wait_idle();

    // asynchronous reset on the 5th FILL pixel
    @(negedge clock);
    req_tile = 2'b00; req_colour = 3'd6; req_restore = 3'd1; req_flash = 1'b1; req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) req = 1'b0;
    end
    check("pre_reset_pixel", 64'({plot, x, y}), 64'({1'b1, 8'd0, 7'd1}));
    #1 reset = 1'b1;
    #1 check("async_reset_outputs", 64'({ack, busy, plot, done, x, y, colour}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (plot || done || busy) bad++;
    end
    check("no_activity_after_abort", 64'(bad), 64'd0);
    $display("txn reset_abort activity_cycles=%0d", bad);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
